hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed-depth hazard and forward pair used in the 5-stage core.
- Tracks in-flight register writes across NSTAGES post-decode pipeline slots, for NRPORTS source operands.
- Each write carries a per-instruction result-ready stage, so ALU ops forward early and loads or longer ops stall exactly as long as needed.
- Sits beside the ID/EX boundary. Drives the decode stall and registered EX-stage forward selects, and keeps a stall-cycle performance counter.

Parameters:
- RFIDX_WIDTH, 5: register index width.
- NSTAGES, 3: tracked slots after decode. Slot 0 = EX, slot NSTAGES-1 = WB. Legal range 2..8.
- NRPORTS, 2: source operand ports checked per decode instruction.
- SELW, 3: width of each forward select and ready-stage field. Must satisfy 2^SELW >= NSTAGES.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- issue_valid  in  1  valid instruction in decode
- issue_regwrite  in  1  decode instruction writes rd
- issue_rd  in  RFIDX_WIDTH  decode destination
- issue_rdy_stage  in  SELW  slot at whose end the result exists: 0 = ALU, 1 = load. Must be <= NSTAGES-2.
- rs_addr  in  NRPORTS*RFIDX_WIDTH  decode source indices, port p at [p*RFIDX_WIDTH +: RFIDX_WIDTH]
- rs_used  in  NRPORTS  port p actually reads its register
- flush  in  1  branch/jump resolved in EX; discard decode instruction
- stall_d  out  1  hold PC and IF/ID, insert bubble into EX (combinational)
- fwd_sel_e  out  NRPORTS*SELW  registered per-port source for the instruction now in EX: 0 = regfile value, k = slot k result
- stall_cycles  out  32  saturating count of cycles with stall_d=1

Behaviour:
Slot contents and reset
- Slot entry fields: valid, rd, rdy_stage.
- Async reset: all slots invalid, fwd_sel_e = 0, stall_cycles = 0. Therefore stall_d = 0 while and immediately after reset.

Shift
- Every clock edge, slot s moves to slot s+1 and slot NSTAGES-1 retires. There is no hold.
- Slot 0 loads the decode entry when issue_valid & issue_regwrite & (issue_rd != 0) & !stall_d & !flush. Otherwise slot 0 loads a bubble (invalid).

Match
- For port p, consider slots 0..NSTAGES-2 only.
- A slot matches when: rs_used[p], rs_addr[p] != 0, slot valid, and slot rd == rs_addr[p].
- Slot NSTAGES-1 is never matched: the regfile is write-first and supplies that value in decode.
- If several slots match, the youngest (lowest s) wins.

Stall
- Port p hazard: winning match at slot s with rdy_stage > s.
- stall_d = issue_valid & !flush & OR of port hazards.
- Examples at default depth: an ALU producer in slot 0 never stalls. A load producer in slot 0 gives a one-cycle stall; the load is in slot 1 on the next cycle, so no stall then.

Forward select
- If no stall, no flush and issue_valid: fwd_sel_e[p] <= winning s+1, or 0 if no match.
- Otherwise: fwd_sel_e <= 0, because a bubble is entering EX.
- Select 1 equals aluoutM, select 2 equals the WB result. Latency: one cycle, aligned with the ID/EX register.

Flush and simultaneous events
- flush overrides stall: decode is discarded, no stall is counted, and the slot 0 entry still shifts normally.
- Wrap: a decode entry that writes an rd already in flight simply creates a newer slot. Matching is youngest-first, so WAW needs no special handling.

Counter
- stall_cycles increments on each edge where stall_d = 1.
- Saturates at 0xFFFFFFFF and does not wrap.

Reset mid-operation
- All in-flight entries are discarded immediately. There are no spurious stalls afterwards.

Test Plan:
1. ALU chain, default params. Issue add x5 (rdy 0), then add x6,x5,x5. Required: stall_d = 0; fwd_sel_e = {1,1} in the cycle the second add is in EX.
2. Load-use. Issue lw x7 (rdy 1), then sub x8,x7,x0 with rs_used = 2'b01. Required: stall_d = 1 for exactly one cycle; stall_cycles = 1; then fwd_sel_e port 0 = 2 and fwd_sel_e port 1 = 0.
3. Youngest wins. Issue add x3, add x3, then or x4,x3,x3. Required: both ports select 1, not 2.
4. x0 and unused ports. Issue add x0, then add x1,x0,x9 with rs_used = 2'b01. Required: stall_d = 0; fwd_sel_e = {0,0}.
5. Flush. Present load-use as in case 2 with flush = 1 in the same cycle. Required: stall_d = 0; fwd_sel_e = 0 next cycle; stall_cycles unchanged; the load still appears in slot 1.
6. Depth and reset. Run NSTAGES = 5, NRPORTS = 3 with a producer of rdy 3. Required: a dependent gets 3 stall cycles, then select 4. Assert reset mid-stall: stall_d = 0 at once; all outputs 0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode-side interface for the hazard scoreboard.
// The decode stage presents one instruction and receives the stall and the EX forward selects.
interface hazard_scoreboard_if #(
  parameter int unsigned RFIDX_WIDTH = 5,
  parameter int unsigned NRPORTS     = 2,
  parameter int unsigned SELW        = 3
);
  logic                           issue_valid;
  logic                           issue_regwrite;
  logic [RFIDX_WIDTH-1:0]         issue_rd;
  logic [SELW-1:0]                issue_rdy_stage;
  logic [NRPORTS*RFIDX_WIDTH-1:0] rs_addr;
  logic [NRPORTS-1:0]             rs_used;
  logic                           flush;
  logic                           stall_d;
  logic [NRPORTS*SELW-1:0]        fwd_sel_e;
  logic [31:0]                    stall_cycles;

  modport master (
    output issue_valid, issue_regwrite, issue_rd, issue_rdy_stage, rs_addr, rs_used, flush,
    input  stall_d, fwd_sel_e, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_regwrite, issue_rd, issue_rdy_stage, rs_addr, rs_used, flush,
    output stall_d, fwd_sel_e, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight register writes over NSTAGES post-decode slots
// (slot 0 = EX, slot NSTAGES-1 = WB), raises the decode stall for results that are not
// ready yet, and registers per-port forward selects for the instruction entering EX.
module hazard_scoreboard #(
  parameter int unsigned RFIDX_WIDTH = 5,
  parameter int unsigned NSTAGES     = 3,
  parameter int unsigned NRPORTS     = 2,
  parameter int unsigned SELW        = 3
) (
  input logic          clk,
  input logic          reset,
  hazard_scoreboard_if.slave sb
);

  typedef struct packed {
    logic                   valid;
    logic [RFIDX_WIDTH-1:0] rd;
    logic [SELW-1:0]        rdyStage;
  } slotT;

  slotT                    slots [NSTAGES];
  logic [NRPORTS-1:0]      hit;
  logic [NRPORTS-1:0]      hazard;
  logic [SELW-1:0]         hitSel [NRPORTS];
  logic                    stall;
  logic                    enter;
  logic                    fwdGo;
  logic [NRPORTS*SELW-1:0] fwdNext;
  logic [NRPORTS*SELW-1:0] fwdSel;
  logic [31:0]             stallCnt;

  // Per-port match over slots 0..NSTAGES-2; scanned oldest first so the youngest match wins.
  always_comb begin
    hit    = '0;
    hazard = '0;
    for (int unsigned p = 0; p < NRPORTS; p++) begin
      hitSel[p] = '0;
      for (int unsigned i = 0; i < NSTAGES - 1; i++) begin
        if (sb.rs_used[p] &&
            (sb.rs_addr[p*RFIDX_WIDTH +: RFIDX_WIDTH] != '0) &&
            slots[NSTAGES-2-i].valid &&
            (slots[NSTAGES-2-i].rd == sb.rs_addr[p*RFIDX_WIDTH +: RFIDX_WIDTH])) begin
          hit[p]    = 1'b1;
          hitSel[p] = SELW'(NSTAGES - 1 - i);
          hazard[p] = slots[NSTAGES-2-i].rdyStage > SELW'(NSTAGES - 2 - i);
        end
      end
    end
  end

  // Stall, slot-0 admission and next forward selects.
  always_comb begin
    stall   = sb.issue_valid & ~sb.flush & (|hazard);
    enter   = sb.issue_valid & sb.issue_regwrite & (sb.issue_rd != '0) & ~stall & ~sb.flush;
    fwdGo   = sb.issue_valid & ~sb.flush & ~stall;
    fwdNext = '0;
    for (int unsigned p = 0; p < NRPORTS; p++) begin
      if (fwdGo && hit[p]) begin
        fwdNext[p*SELW +: SELW] = hitSel[p];
      end
    end
  end

  // Slot shift register: every edge advances, slot 0 takes the decode entry or a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < NSTAGES; s++) begin
        slots[s] <= '0;
      end
    end else begin
      for (int unsigned s = 1; s < NSTAGES; s++) begin
        slots[s] <= slots[s-1];
      end
      if (enter) begin
        slots[0] <= '{valid: 1'b1, rd: sb.issue_rd, rdyStage: sb.issue_rdy_stage};
      end else begin
        slots[0] <= '0;
      end
    end
  end

  // EX-stage forward selects, aligned with the ID/EX register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwdSel <= '0;
    end else begin
      fwdSel <= fwdNext;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
    end else if (stall && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 32'd1;
    end
  end

  assign sb.stall_d      = stall;
  assign sb.fwd_sel_e    = fwdSel;
  assign sb.stall_cycles = stallCnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: the driver pushes the hand-computed expectation for each cycle,
// a monitor pops and compares on the falling edge.
module tb_hazard_scoreboard;

  logic clk  = 1'b0;
  logic rstA = 1'b1;
  logic rstB = 1'b1;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.RFIDX_WIDTH(5), .NRPORTS(2), .SELW(3)) ifA ();
  hazard_scoreboard_if #(.RFIDX_WIDTH(5), .NRPORTS(3), .SELW(3)) ifB ();

  hazard_scoreboard #(.RFIDX_WIDTH(5), .NSTAGES(3), .NRPORTS(2), .SELW(3)) dutA (
    .clk(clk), .reset(rstA), .sb(ifA)
  );

  hazard_scoreboard #(.RFIDX_WIDTH(5), .NSTAGES(5), .NRPORTS(3), .SELW(3)) dutB (
    .clk(clk), .reset(rstB), .sb(ifB)
  );

  typedef struct {
    int          dut;
    string       name;
    logic        expStall;
    logic [8:0]  expFwd;
    logic [31:0] expCnt;
  } expT;

  expT expQ [$];
  int  total = 0;
  int  bad   = 0;

  task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, compared away from the rising edge.
  initial begin
    expT         e;
    logic        aS;
    logic [8:0]  aF;
    logic [31:0] aC;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        if (e.dut == 0) begin
          aS = ifA.stall_d;
          aF = {3'b000, ifA.fwd_sel_e};
          aC = ifA.stall_cycles;
        end else begin
          aS = ifB.stall_d;
          aF = ifB.fwd_sel_e;
          aC = ifB.stall_cycles;
        end
        checkVal({e.name, ".stall_d"}, {31'd0, aS}, {31'd0, e.expStall});
        checkVal({e.name, ".fwd_sel_e"}, {23'd0, aF}, {23'd0, e.expFwd});
        checkVal({e.name, ".stall_cycles"}, aC, e.expCnt);
      end
    end
  end

  // Drive one decode cycle on the chosen DUT and queue what it must show this cycle.
  task automatic cyc(input int dut, input bit rst, input bit v, input bit rw, input int rd,
                     input int rdy, input int rs0, input int rs1, input int rs2, input int used,
                     input bit fl, input bit eS, input int eF, input int eC, input string nm);
    expT e;
    if (dut == 0) begin
      rstA                = rst;
      ifA.issue_valid     = v;
      ifA.issue_regwrite  = rw;
      ifA.issue_rd        = 5'(rd);
      ifA.issue_rdy_stage = 3'(rdy);
      ifA.rs_addr         = {5'(rs1), 5'(rs0)};
      ifA.rs_used         = 2'(used);
      ifA.flush           = fl;
    end else begin
      rstB                = rst;
      ifB.issue_valid     = v;
      ifB.issue_regwrite  = rw;
      ifB.issue_rd        = 5'(rd);
      ifB.issue_rdy_stage = 3'(rdy);
      ifB.rs_addr         = {5'(rs2), 5'(rs1), 5'(rs0)};
      ifB.rs_used         = 3'(used);
      ifB.flush           = fl;
    end
    e.dut      = dut;
    e.name     = nm;
    e.expStall = eS;
    e.expFwd   = 9'(eF);
    e.expCnt   = 32'(eC);
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifA.issue_valid = 1'b0; ifA.issue_regwrite = 1'b0; ifA.issue_rd = '0;
    ifA.issue_rdy_stage = '0; ifA.rs_addr = '0; ifA.rs_used = '0; ifA.flush = 1'b0;
    ifB.issue_valid = 1'b0; ifB.issue_regwrite = 1'b0; ifB.issue_rd = '0;
    ifB.issue_rdy_stage = '0; ifB.rs_addr = '0; ifB.rs_used = '0; ifB.flush = 1'b0;
    @(posedge clk);
    #1;
    //   dut rst v  rw rd rdy rs0 rs1 rs2 used fl  stall fwd cnt
    cyc(0, 1, 0, 0, 0, 0,  0,  0,  0, 0,   0,  0,    0,   0, "a_reset");
    // ALU chain
    cyc(0, 0, 1, 1, 5, 0,  1,  2,  0, 3,   0,  0,    0,   0, "t1_prod");
    cyc(0, 0, 1, 1, 6, 0,  5,  5,  0, 3,   0,  0,    0,   0, "t1_dep");
    cyc(0, 0, 0, 0, 0, 0,  0,  0,  0, 0,   0,  0,    9,   0, "t1_fwd");
    // load-use
    cyc(0, 0, 1, 1, 7, 1,  0,  0,  0, 0,   0,  0,    0,   0, "t2_load");
    cyc(0, 0, 1, 1, 8, 0,  7,  0,  0, 1,   0,  1,    0,   0, "t2_stall");
    cyc(0, 0, 1, 1, 8, 0,  7,  0,  0, 1,   0,  0,    0,   1, "t2_release");
    cyc(0, 0, 0, 0, 0, 0,  0,  0,  0, 0,   0,  0,    2,   1, "t2_fwd");
    // youngest wins
    cyc(0, 0, 1, 1, 3, 0,  0,  0,  0, 0,   0,  0,    0,   1, "t3_old");
    cyc(0, 0, 1, 1, 3, 0,  0,  0,  0, 0,   0,  0,    0,   1, "t3_young");
    cyc(0, 0, 1, 1, 4, 0,  3,  3,  0, 3,   0,  0,    0,   1, "t3_dep");
    cyc(0, 0, 0, 0, 0, 0,  0,  0,  0, 0,   0,  0,    9,   1, "t3_fwd");
    // x0 and unused ports (x9 in flight but read only on an unused port)
    cyc(0, 0, 1, 1, 9, 1,  0,  0,  0, 0,   0,  0,    0,   1, "t4_x9");
    cyc(0, 0, 1, 1, 0, 0,  0,  0,  0, 0,   0,  0,    0,   1, "t4_x0");
    cyc(0, 0, 1, 1, 1, 0,  0,  9,  0, 1,   0,  0,    0,   1, "t4_dep");
    cyc(0, 0, 0, 0, 0, 0,  0,  0,  0, 0,   0,  0,    0,   1, "t4_fwd");
    // flush overrides stall; the load keeps moving
    cyc(0, 0, 1, 1, 7, 1,  0,  0,  0, 0,   0,  0,    0,   1, "t5_load");
    cyc(0, 0, 1, 1, 8, 0,  7,  0,  0, 1,   1,  0,    0,   1, "t5_flush");
    cyc(0, 0, 1, 1, 8, 0,  7,  0,  0, 1,   0,  0,    0,   1, "t5_slot1");
    cyc(0, 0, 0, 0, 0, 0,  0,  0,  0, 0,   0,  0,    2,   1, "t5_fwd");
    // deep configuration
    cyc(1, 1, 0, 0, 0, 0,  0,  0,  0, 0,   0,  0,    0,   0, "b_reset");
    cyc(1, 0, 1, 1, 10, 3, 0,  0,  0, 0,   0,  0,    0,   0, "t6_prod");
    cyc(1, 0, 1, 1, 12, 0, 10, 3, 10, 5,   0,  1,    0,   0, "t6_stall0");
    cyc(1, 0, 1, 1, 12, 0, 10, 3, 10, 5,   0,  1,    0,   1, "t6_stall1");
    cyc(1, 0, 1, 1, 12, 0, 10, 3, 10, 5,   0,  1,    0,   2, "t6_stall2");
    cyc(1, 0, 1, 1, 12, 0, 10, 3, 10, 5,   0,  0,    0,   3, "t6_release");
    cyc(1, 0, 0, 0, 0, 0,  0,  0,  0, 0,   0,  0,  260,   3, "t6_fwd");
    cyc(1, 0, 1, 1, 11, 3, 0,  0,  0, 0,   0,  0,    0,   3, "t6_prod2");
    cyc(1, 0, 1, 1, 13, 0, 11, 0,  0, 1,   0,  1,    0,   3, "t6_stall");
    cyc(1, 1, 1, 1, 13, 0, 11, 0,  0, 1,   0,  0,    0,   0, "t6_midreset");
    cyc(1, 0, 1, 1, 13, 0, 11, 0,  0, 1,   0,  0,    0,   0, "t6_after");
    cyc(1, 0, 0, 0, 0, 0,  0,  0,  0, 0,   0,  0,    0,   0, "t6_idle");
    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(posedge clk);
    end
    if (expQ.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
